// File: rtl/config_pkg.sv
// Shared definitions for the configuration chain loader: FSM encoding and
// helpers that derive counter widths from the chain and word geometry.
package config_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int unsigned bit_cnt_width(input int unsigned chain_length);
    return $clog2(chain_length + 1);
  endfunction

  function automatic int unsigned words_needed(input int unsigned chain_length,
                                               input int unsigned word_width);
    return (chain_length + word_width - 1) / word_width;
  endfunction

  function automatic int unsigned word_cnt_width(input int unsigned chain_length,
                                                 input int unsigned word_width);
    return $clog2(words_needed(chain_length, word_width) + 1);
  endfunction

endpackage

// File: rtl/config_shifter.sv
// Word-to-bit serializer feeding the chain, plus MSB-first packing of the
// bits returning from the far end of the chain into readback words.
module config_shifter #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  clear,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  chain_return,
  output logic                  chain_out,
  output logic                  chain_en,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid
);

  localparam int unsigned RCW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic                  chain_out_q, chain_out_d;
  logic                  chain_en_q, chain_en_d;
  logic [WORD_WIDTH-1:0] rb_sr_q, rb_sr_d;
  logic [RCW-1:0]        rb_cnt_q, rb_cnt_d;
  logic [WORD_WIDTH-1:0] rb_word_q, rb_word_d;
  logic                  rb_valid_q, rb_valid_d;
  logic [WORD_WIDTH-1:0] rb_next;
  logic [RCW-1:0]        rb_cnt_next;

  // Serializer: a load presents the word MSB next cycle, advance walks down.
  always_comb begin
    sr_d        = sr_q;
    chain_out_d = chain_out_q;
    chain_en_d  = 1'b0;
    if (load) begin
      chain_out_d = word_in[WORD_WIDTH-1];
      sr_d        = word_in << 1;
      chain_en_d  = 1'b1;
    end else if (advance) begin
      chain_out_d = sr_q[WORD_WIDTH-1];
      sr_d        = sr_q << 1;
      chain_en_d  = 1'b1;
    end
  end

  // Readback: sample chain_return on every enabled cycle; a flush on the
  // final chain bit left-aligns whatever partial word has accumulated.
  always_comb begin
    rb_sr_d     = rb_sr_q;
    rb_cnt_d    = rb_cnt_q;
    rb_word_d   = rb_word_q;
    rb_valid_d  = 1'b0;
    rb_next     = WORD_WIDTH'({rb_sr_q, chain_return});
    rb_cnt_next = rb_cnt_q + RCW'(1);
    if (clear) begin
      rb_sr_d  = '0;
      rb_cnt_d = '0;
    end else if (chain_en_q) begin
      if (rb_cnt_next == RCW'(WORD_WIDTH)) begin
        rb_word_d  = rb_next;
        rb_valid_d = 1'b1;
        rb_sr_d    = '0;
        rb_cnt_d   = '0;
      end else if (flush) begin
        rb_word_d  = rb_next << (RCW'(WORD_WIDTH) - rb_cnt_next);
        rb_valid_d = 1'b1;
        rb_sr_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sr_d  = rb_next;
        rb_cnt_d = rb_cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q        <= '0;
      chain_out_q <= 1'b0;
      chain_en_q  <= 1'b0;
      rb_sr_q     <= '0;
      rb_cnt_q    <= '0;
      rb_word_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      chain_out_q <= chain_out_d;
      chain_en_q  <= chain_en_d;
      rb_sr_q     <= rb_sr_d;
      rb_cnt_q    <= rb_cnt_d;
      rb_word_q   <= rb_word_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

  assign chain_out = chain_out_q;
  assign chain_en  = chain_en_q;
  assign rb_word   = rb_word_q;
  assign rb_valid  = rb_valid_q;

endmodule

// File: rtl/config_loader.sv
// Loads a serial configuration chain from a host word stream, with stall,
// abort and readback of the chain's previous contents.
module config_loader #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned CHAIN_LENGTH = 1024
) (
  input  logic                  config_clk,
  input  logic                  sys_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_out,
  output logic                  chain_en,
  input  logic                  chain_return,
  output logic [WORD_WIDTH-1:0] rb_word,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  import config_pkg::*;

  localparam int unsigned CW    = bit_cnt_width(CHAIN_LENGTH);
  localparam int unsigned WORDS = words_needed(CHAIN_LENGTH, WORD_WIDTH);
  localparam int unsigned WCW   = word_cnt_width(CHAIN_LENGTH, WORD_WIDTH);
  localparam int unsigned BW    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]  wbit_q, wbit_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           aborted_q, aborted_d;

  logic load_c, advance_c, clear_c, flush_c, word_ready_c;
  logic chain_last_c, word_last_c, more_words_c;

  // bit_cnt_q / wbit_q describe the bit currently presented on the chain.
  assign chain_last_c = (bit_cnt_q == CW'(CHAIN_LENGTH));
  assign word_last_c  = (wbit_q == BW'(WORD_WIDTH - 1));
  assign more_words_c = (word_cnt_q < WCW'(WORDS));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    wbit_d       = wbit_q;
    word_cnt_d   = word_cnt_q;
    aborted_d    = 1'b0;
    load_c       = 1'b0;
    advance_c    = 1'b0;
    clear_c      = 1'b0;
    flush_c      = 1'b0;
    word_ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        word_ready_c = start;
        if (start && word_valid) begin
          load_c     = 1'b1;
          clear_c    = 1'b1;
          bit_cnt_d  = CW'(1);
          wbit_d     = '0;
          word_cnt_d = WCW'(1);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        word_ready_c = word_last_c && !chain_last_c && more_words_c;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (chain_last_c) begin
          flush_c = 1'b1;
          state_d = ST_DONE;
        end else if (word_last_c) begin
          if (word_ready_c && word_valid) begin
            load_c     = 1'b1;
            bit_cnt_d  = bit_cnt_q + CW'(1);
            wbit_d     = '0;
            word_cnt_d = word_cnt_q + WCW'(1);
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          advance_c = 1'b1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          wbit_d    = wbit_q + BW'(1);
        end
      end
      ST_STALL: begin
        word_ready_c = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (word_valid) begin
          load_c     = 1'b1;
          bit_cnt_d  = bit_cnt_q + CW'(1);
          wbit_d     = '0;
          word_cnt_d = word_cnt_q + WCW'(1);
          state_d    = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_STALL);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge config_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wbit_q     <= '0;
      word_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wbit_q     <= wbit_d;
      word_cnt_q <= word_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  config_shifter #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_shifter (
    .clk          (config_clk),
    .rst_n        (sys_reset),
    .load         (load_c),
    .advance      (advance_c),
    .clear        (clear_c),
    .flush        (flush_c),
    .word_in      (word_in),
    .chain_return (chain_return),
    .chain_out    (chain_out),
    .chain_en     (chain_en),
    .rb_word      (rb_word),
    .rb_valid     (rb_valid)
  );

  // Ready depends on start in IDLE, so it cannot be a flop; hold it low in reset.
  assign word_ready = word_ready_c && sys_reset;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with an 8-bit word and a 20-bit chain model.
module tb_config_loader;

  localparam int unsigned WW = 8;
  localparam int unsigned CL = 20;

  logic          config_clk = 1'b0;
  logic          sys_reset  = 1'b1;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic [WW-1:0] word_in    = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          chain_out;
  logic          chain_en;
  logic          chain_return;
  logic [WW-1:0] rb_word;
  logic          rb_valid;
  logic          busy;
  logic          done;
  logic          aborted;

  logic [CL-1:0] chain_q;
  logic          preload_en  = 1'b0;
  logic [CL-1:0] preload_val = '0;

  int tests = 0;
  int fails = 0;

  logic [WW-1:0] words [3];

  int            en_cnt, gap_cyc, pending, done_cnt, abort_cnt, rb_cnt, busy_bad;
  int            first_en_cyc, last_en_cyc, done_cyc;
  bit            seen_en;
  logic [CL-1:0] bits;
  logic [WW-1:0] rb_w [4];

  always #5 config_clk = ~config_clk;

  config_loader #(
    .WORD_WIDTH   (WW),
    .CHAIN_LENGTH (CL)
  ) dut (
    .config_clk   (config_clk),
    .sys_reset    (sys_reset),
    .start        (start),
    .abort        (abort),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .chain_out    (chain_out),
    .chain_en     (chain_en),
    .chain_return (chain_return),
    .rb_word      (rb_word),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  // Chain of 20 config elements; config_out of the last one is chain_q[CL-1].
  always @(posedge config_clk) begin
    if (preload_en) chain_q <= preload_val;
    else if (chain_en) chain_q <= {chain_q[CL-2:0], chain_out};
  end
  assign chain_return = chain_q[CL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge config_clk);
    #1;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    step();
    preload_en  = 1'b0;
  endtask

  task automatic monitor(input int cyc);
    if (chain_en) begin
      en_cnt++;
      bits    = {bits[CL-2:0], chain_out};
      gap_cyc = gap_cyc + pending;
      pending = 0;
      if (!seen_en) first_en_cyc = cyc;
      seen_en     = 1'b1;
      last_en_cyc = cyc;
      if (!busy) busy_bad++;
    end else if (seen_en) begin
      pending++;
    end
    if (rb_valid) begin
      if (rb_cnt < 4) rb_w[rb_cnt] = rb_word;
      rb_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (aborted) abort_cnt++;
  endtask

  task automatic run_load(input int gap, input int abort_bit, input int start_bit,
                          input int reset_bit);
    int sent, cyc, gap_left;
    bit fire, finished, stop;
    sent = 0; cyc = 0; gap_left = gap; finished = 1'b0; stop = 1'b0;
    en_cnt = 0; gap_cyc = 0; pending = 0; done_cnt = 0; abort_cnt = 0;
    rb_cnt = 0; busy_bad = 0; first_en_cyc = -1; last_en_cyc = -1; done_cyc = -1;
    seen_en = 1'b0; bits = '0;
    for (int i = 0; i < 4; i++) rb_w[i] = '0;
    while (!finished && !stop && cyc < 80) begin
      start      = (sent == 0) || (start_bit > 0 && en_cnt == start_bit && chain_en);
      abort      = (abort_bit > 0 && en_cnt == abort_bit && chain_en);
      word_valid = (sent < 3) && !(sent == 1 && gap_left > 0);
      word_in    = (sent < 3) ? words[sent] : '0;
      #1;
      fire = word_ready && word_valid && !abort;
      if (word_ready && !word_valid && sent == 1 && gap_left > 0) gap_left--;
      @(posedge config_clk);
      #1;
      cyc++;
      if (fire) sent++;
      monitor(cyc);
      if (done || aborted) finished = 1'b1;
      if (reset_bit > 0 && en_cnt == reset_bit) begin
        sys_reset = 1'b0;
        #1;
        chk("rst_mid_chain_en",   32'(chain_en),   32'd0);
        chk("rst_mid_chain_out",  32'(chain_out),  32'd0);
        chk("rst_mid_busy",       32'(busy),       32'd0);
        chk("rst_mid_word_ready", 32'(word_ready), 32'd0);
        chk("rst_mid_rb_valid",   32'(rb_valid),   32'd0);
        chk("rst_mid_rb_word",    32'(rb_word),    32'd0);
        chk("rst_mid_done_abort", 32'({done, aborted}), 32'd0);
        stop = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    if (reset_bit == 0) begin
      chk("load_terminated", 32'(finished), 32'd1);
      for (int i = 0; i < 3; i++) begin
        step();
        cyc++;
        monitor(cyc);
      end
    end
  endtask

  task automatic check_full_load(input string tag);
    chk({tag, "_en_cycles"},   32'(en_cnt),      32'd20);
    chk({tag, "_bits"},        32'(bits),        32'hA53CF);
    chk({tag, "_chain"},       32'(chain_q),     32'hA53CF);
    chk({tag, "_done_cnt"},    32'(done_cnt),    32'd1);
    chk({tag, "_done_timing"}, 32'(done_cyc),    32'(last_en_cyc + 1));
    chk({tag, "_abort_cnt"},   32'(abort_cnt),   32'd0);
    chk({tag, "_busy_in_shift"}, 32'(busy_bad),  32'd0);
    chk({tag, "_end_busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hF7;

    // Reset values
    #2 sys_reset = 1'b0;
    #1;
    chk("rst_chain_en",  32'(chain_en),  32'd0);
    chk("rst_chain_out", 32'(chain_out), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_aborted",   32'(aborted),   32'd0);
    chk("rst_rb",        32'({rb_valid, rb_word}), 32'd0);
    chk("rst_ready",     32'(word_ready), 32'd0);
    step();
    step();
    sys_reset = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    #1;
    chk("idle_ready_start", 32'(word_ready), 32'd1);
    start = 1'b0;
    #1;
    chk("idle_ready_nostart", 32'(word_ready), 32'd0);

    // Abort while idle does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_aborted", 32'(aborted), 32'd0);
    chk("idle_abort_busy",    32'(busy),    32'd0);

    // Full load with valid held, readback of preloaded chain
    preload(20'hABCDE);
    run_load(0, 0, 0, 0);
    check_full_load("basic");
    chk("basic_first_en",  32'(first_en_cyc), 32'd1);
    chk("basic_gap",       32'(gap_cyc),      32'd0);
    chk("basic_rb_cnt",    32'(rb_cnt),       32'd3);
    chk("basic_rb0",       32'(rb_w[0]),      32'hAB);
    chk("basic_rb1",       32'(rb_w[1]),      32'hCD);
    chk("basic_rb2",       32'(rb_w[2]),      32'hE0);

    // Host stalls for three due cycles between first and second words
    preload(20'hABCDE);
    run_load(3, 0, 0, 0);
    check_full_load("stall");
    chk("stall_gap",    32'(gap_cyc), 32'd3);
    chk("stall_rb_cnt", 32'(rb_cnt),  32'd3);
    chk("stall_rb2",    32'(rb_w[2]), 32'hE0);

    // Abort during the 10th bit
    preload(20'hABCDE);
    run_load(0, 10, 0, 0);
    chk("abort_en_cycles", 32'(en_cnt),    32'd10);
    chk("abort_pulses",    32'(abort_cnt), 32'd1);
    chk("abort_no_done",   32'(done_cnt),  32'd0);
    chk("abort_rb_cnt",    32'(rb_cnt),    32'd1);
    chk("abort_rb0",       32'(rb_w[0]),   32'hAB);
    chk("abort_bits",      32'(bits),      32'h00294);
    chk("abort_chain",     32'(chain_q),   32'h37A94);
    chk("abort_busy",      32'(busy),      32'd0);

    // Reset mid-shift, then a clean load with a stray start while busy
    run_load(0, 0, 0, 5);
    step();
    step();
    sys_reset = 1'b1;
    step();
    chk("post_rst_busy",  32'(busy),     32'd0);
    chk("post_rst_en",    32'(chain_en), 32'd0);
    chk("post_rst_pulse", 32'({done, aborted}), 32'd0);
    start = 1'b1;
    #1;
    chk("post_rst_idle_ready", 32'(word_ready), 32'd1);
    start = 1'b0;
    run_load(0, 0, 5, 0);
    check_full_load("restart");
    chk("restart_rb_cnt", 32'(rb_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
